exc_ctrl: RTL

- Exception/interrupt sequencer directly upstream of the interrupt address register.
- Detects overflow, trap-instruction and external IRQ events, and arbitrates them by priority.
- Drives the handshake that makes the interrupt address register capture the return PC: s_u, exception, oint_ex, trap.
- Redirects fetch to the handler vector, and back to the saved PC on return-from-exception.

---
 rtl/exc_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / interrupt sequencer feeding the interrupt address
// register. It detects overflow, trap and external IRQ events, picks one
// event by priority and steers fetch to the handler vector. On
// return-from-exception it steers fetch back to the saved PC.
// Optional feature: define IRQ_MASK_EN to add the mask_we/mask_wd write port
// and a per-line IRQ mask register. The mask resets to all-masked.
module exc_ctrl #(
  parameter int          NIRQ     = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            ovf_ex,
  input  logic            memwrite_ex,
  input  logic            trap_ex,
  input  logic            rfe_ex,
`ifdef IRQ_MASK_EN
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
`endif
  input  logic [31:0]     iar_pc,
  output logic            s_u,
  output logic            exception,
  output logic            oint_ex,
  output logic            trap,
  output logic            flush,
  output logic [1:0]      pc_sel,
  output logic [31:0]     pc_vec,
  output logic [3:0]      cause
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENTER  = 2'd1;
  localparam logic [1:0] SUPER  = 2'd2;
  localparam logic [1:0] RETURN = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_VEC = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;

  logic [1:0]      state;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr;
  logic            irq_hit;
  logic [2:0]      irq_idx;
  logic            take;
  logic [3:0]      evt_cause;

  assign irq_rise = irq & ~irq_q;

`ifdef IRQ_MASK_EN
  logic [NIRQ-1:0] mask;

  // The mask is writable only from supervisor mode. It resets to fully masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mask <= '1;
    else if (mask_we && !s_u)
      mask <= mask_wd;
  end

  assign eligible = pending & ~mask;
`else
  assign eligible = pending;
`endif

  // Find the lowest-numbered eligible pending IRQ.
  // The loop scans downward so that the last hit is the lowest index.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_hit = 1'b1;
        irq_idx = 3'(i);
      end
    end
  end

  // Decide acceptance and the cause code. An accepted IRQ is flagged for clearing.
  always_comb begin
    take = (state == IDLE) && (ovf_ex || trap_ex || irq_hit);
    if (ovf_ex)
      evt_cause = 4'd1;
    else if (trap_ex)
      evt_cause = 4'd2;
    else
      evt_cause = 4'd8 + {1'b0, irq_idx};
    clr = '0;
    if (take && !ovf_ex && !trap_ex)
      clr = NIRQ'(1) << irq_idx;
  end

  // Track IRQ edges. A new rising edge beats a same-cycle clear, so the bit stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr) | irq_rise;
    end
  end

  // Sequencer: IDLE (user) -> ENTER -> SUPER -> RETURN -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SUPER;
      s_u       <= 1'b0;
      exception <= 1'b0;
      oint_ex   <= 1'b0;
      trap      <= 1'b0;
      flush     <= 1'b0;
      pc_sel    <= PC_SEQ;
      pc_vec    <= '0;
      cause     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            cause     <= evt_cause;
            oint_ex   <= (ovf_ex & memwrite_ex) | ovf_ex;
            trap      <= trap_ex;
            s_u       <= 1'b0;
            exception <= 1'b1;
            flush     <= 1'b1;
            pc_sel    <= PC_VEC;
            pc_vec    <= VEC_BASE;
            state     <= ENTER;
          end
        end
        ENTER: begin
          exception <= 1'b0;
          flush     <= 1'b0;
          pc_sel    <= PC_SEQ;
          oint_ex   <= 1'b0;
          trap      <= 1'b0;
          state     <= SUPER;
        end
        SUPER: begin
          if (rfe_ex) begin
            pc_sel <= PC_RET;
            pc_vec <= iar_pc;
            flush  <= 1'b1;
            state  <= RETURN;
          end
        end
        RETURN: begin
          s_u    <= 1'b1;
          pc_sel <= PC_SEQ;
          flush  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= SUPER;
      endcase
    end
  end

endmodule
